// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use and MDU-busy stalls, redirect flushes,
// and a saturating stall-cycle counter for performance debug.
module hazard_stall_ctrl #(
  parameter int unsigned MDU_LAT = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_MemWrite,
  input  logic             ID_MduUse,
  input  logic [4:0]       EX_rt,
  input  logic             EX_RegWrite,
  input  logic             EX_MemToReg,
  input  logic             EX_MduStart,
  input  logic             EX_Redirect,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             MduBusy,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int unsigned BW = $clog2(MDU_LAT + 1);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] busy_cnt, busy_cnt_nxt;
  logic          load_use;
  logic          mdu_stall;
  logic          stall;

  // A store matching only on rt gets its data via WB forwarding, so it does not stall.
  always_comb begin
    load_use  = EX_RegWrite & EX_MemToReg & (EX_rt != 5'd0) &
                ((ID_UseRs & (ID_rs == EX_rt)) |
                 (ID_UseRt & (ID_rt == EX_rt) & ~ID_MemWrite));
    mdu_stall = (state == MDU_BUSY) & ID_MduUse;
    stall     = (load_use | mdu_stall) & ~EX_Redirect;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      busy_cnt <= '0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
    end
  end

  // Next state and pipeline controls; outputs are forced to free-run while in reset.
  always_comb begin
    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;

    unique case (state)
      RUN: begin
        if (EX_MduStart) begin
          state_nxt    = MDU_BUSY;
          busy_cnt_nxt = BW'(MDU_LAT);
        end
      end
      MDU_BUSY: begin
        if (EX_MduStart) begin
          busy_cnt_nxt = BW'(MDU_LAT);
        end else if (busy_cnt == BW'(1)) begin
          state_nxt    = RUN;
          busy_cnt_nxt = '0;
        end else begin
          busy_cnt_nxt = busy_cnt - BW'(1);
        end
      end
      default: begin
        state_nxt    = RUN;
        busy_cnt_nxt = '0;
      end
    endcase

    if (rst_n) begin
      if (EX_Redirect) begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end else if (stall) begin
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end
    end
  end

  assign MduBusy = (state == MDU_BUSY);

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt <= '0;
    end else if (stall && (StallCnt != {CNT_W{1'b1}})) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a wide-counter and a 4-bit-counter
// instance share stimulus and are checked against a behavioural model.
module tb_hazard_stall_ctrl;

  localparam int unsigned MDU_LAT = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] ID_rs, ID_rt, EX_rt;
  logic ID_UseRs, ID_UseRt, ID_MemWrite, ID_MduUse;
  logic EX_RegWrite, EX_MemToReg, EX_MduStart, EX_Redirect;
  logic PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MduBusy;
  logic [31:0] StallCnt;
  logic s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_mdu_busy;
  logic [3:0] s_stall_cnt;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_MemWrite(ID_MemWrite), .ID_MduUse(ID_MduUse),
    .EX_rt(EX_rt), .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
    .EX_MduStart(EX_MduStart), .EX_Redirect(EX_Redirect),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .MduBusy(MduBusy), .StallCnt(StallCnt)
  );

  hazard_stall_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_MemWrite(ID_MemWrite), .ID_MduUse(ID_MduUse),
    .EX_rt(EX_rt), .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
    .EX_MduStart(EX_MduStart), .EX_Redirect(EX_Redirect),
    .PC_Write(s_pc_write), .IFID_Write(s_ifid_write), .IFID_Flush(s_ifid_flush),
    .IDEX_Flush(s_idex_flush), .MduBusy(s_mdu_busy), .StallCnt(s_stall_cnt)
  );

  typedef struct {
    string       name;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        mdu_busy;
    logic [31:0] stall_cnt;
    logic [3:0]  stall_cnt_sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  bit   m_busy;
  int   m_cnt;
  int   m_stalls;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_cnt    = 0;
    m_stalls = 0;
  endtask

  // Predict this cycle's outputs, queue them, then advance the model across the edge.
  task automatic step(input string name);
    logic lu, st;
    exp_t e;
    lu = EX_RegWrite & EX_MemToReg & (EX_rt != 5'd0) &
         ((ID_UseRs & (ID_rs == EX_rt)) | (ID_UseRt & (ID_rt == EX_rt) & ~ID_MemWrite));
    st = (lu | (m_busy & ID_MduUse)) & ~EX_Redirect;
    e.name          = name;
    e.pc_write      = EX_Redirect | ~st;
    e.ifid_write    = EX_Redirect | ~st;
    e.ifid_flush    = EX_Redirect;
    e.idex_flush    = EX_Redirect | st;
    e.mdu_busy      = m_busy;
    e.stall_cnt     = 32'(m_stalls);
    e.stall_cnt_sat = (m_stalls > 15) ? 4'd15 : 4'(m_stalls);
    exp_q.push_back(e);
    @(posedge clk);
    if (st) m_stalls++;
    if (!m_busy) begin
      if (EX_MduStart) begin
        m_busy = 1'b1;
        m_cnt  = MDU_LAT;
      end
    end else if (EX_MduStart) begin
      m_cnt = MDU_LAT;
    end else if (m_cnt == 1) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end else begin
      m_cnt--;
    end
    #1;
  endtask

  task automatic drive(input string name, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic mw, input logic mu,
                       input logic [4:0] ert, input logic rw, input logic mtr,
                       input logic ms, input logic rd);
    ID_rs = rs; ID_rt = rt; ID_UseRs = urs; ID_UseRt = urt;
    ID_MemWrite = mw; ID_MduUse = mu;
    EX_rt = ert; EX_RegWrite = rw; EX_MemToReg = mtr;
    EX_MduStart = ms; EX_Redirect = rd;
    step(name);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, " pc_write"},   32'(PC_Write),   32'(e.pc_write));
      chk({e.name, " ifid_write"}, 32'(IFID_Write), 32'(e.ifid_write));
      chk({e.name, " ifid_flush"}, 32'(IFID_Flush), 32'(e.ifid_flush));
      chk({e.name, " idex_flush"}, 32'(IDEX_Flush), 32'(e.idex_flush));
      chk({e.name, " mdu_busy"},   32'(MduBusy),    32'(e.mdu_busy));
      chk({e.name, " stall_cnt"},  StallCnt,        e.stall_cnt);
      chk({e.name, " sat pc_write"},   32'(s_pc_write),   32'(e.pc_write));
      chk({e.name, " sat idex_flush"}, 32'(s_idex_flush), 32'(e.idex_flush));
      chk({e.name, " sat ifid_flush"}, 32'(s_ifid_flush), 32'(e.ifid_flush));
      chk({e.name, " sat ifid_write"}, 32'(s_ifid_write), 32'(e.ifid_write));
      chk({e.name, " sat mdu_busy"},   32'(s_mdu_busy),   32'(e.mdu_busy));
      chk({e.name, " sat stall_cnt"},  32'(s_stall_cnt),  32'(e.stall_cnt_sat));
    end
  end

  initial begin
    rst_n = 1'b0;
    ID_rs = '0; ID_rt = '0; ID_UseRs = 0; ID_UseRt = 0; ID_MemWrite = 0; ID_MduUse = 0;
    EX_rt = '0; EX_RegWrite = 0; EX_MemToReg = 0; EX_MduStart = 0; EX_Redirect = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst pc_write",   32'(PC_Write),   32'd1);
    chk("rst ifid_write", 32'(IFID_Write), 32'd1);
    chk("rst flushes",    32'({IFID_Flush, IDEX_Flush}), 32'd0);
    chk("rst mdu_busy",   32'(MduBusy),    32'd0);
    chk("rst stall_cnt",  StallCnt,        32'd0);
    rst_n = 1'b1;

    //     name          rs rt urs urt mw mu ert rw mtr ms rd
    drive("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("lu_rs",       5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0);
    drive("lu_bubble",   5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("sw_rt",       3, 7, 1, 1, 1, 0, 7, 1, 1, 0, 0);
    drive("sw_rs",       7, 7, 1, 1, 1, 0, 7, 1, 1, 0, 0);
    drive("sw_bubble",   7, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    drive("zero_rt",     0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    drive("alu_ex",      5, 5, 1, 1, 0, 0, 5, 1, 0, 0, 0);
    drive("lu_rt",       1, 6, 1, 1, 0, 0, 6, 1, 1, 0, 0);
    drive("mdu_start",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < MDU_LAT + 1; i++)
      drive($sformatf("mflo%0d", i), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    drive("idle2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("mdu_start2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive("busy_alu",    1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    drive("busy_redir",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    drive("lu_redir",    5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 1);
    drive("busy_mflo",   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of an MDU stall.
    ID_MduUse = 1'b1;
    #1;
    chk("pre_rst stall", 32'(PC_Write), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst pc_write",   32'(PC_Write),   32'd1);
    chk("mid_rst ifid_write", 32'(IFID_Write), 32'd1);
    chk("mid_rst idex_flush", 32'(IDEX_Flush), 32'd0);
    chk("mid_rst ifid_flush", 32'(IFID_Flush), 32'd0);
    chk("mid_rst mdu_busy",   32'(MduBusy),    32'd0);
    chk("mid_rst stall_cnt",  StallCnt,        32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      drive($sformatf("sat%0d", i), 5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0);
    drive("sat_done",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++)
      drive($sformatf("rnd%0d", i),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 7) == 0));

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller that works alongside the forwarding unit. It handles the hazards forwarding cannot resolve: load-use, the multi-cycle multiply/divide unit (MDU) being busy, and taken-branch/jump redirect. It drives the PC and IF/ID write enables plus the IF/ID and ID/EX flush controls, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
MDU_LAT, 8, cycles the MDU stays busy after an MDU op leaves EX (must be ≥1).
CNT_W, 32, width of the stall-cycle counter.

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
ID_rs  input  5  rs field of the instruction in ID
ID_rt  input  5  rt field of the instruction in ID
ID_UseRs  input  1  ID instruction reads rs
ID_UseRt  input  1  ID instruction reads rt
ID_MemWrite  input  1  ID instruction is a store
ID_MduUse  input  1  ID instruction is an MDU op, mfhi or mflo
EX_rt  input  5  rt/destination of the instruction in EX
EX_RegWrite  input  1  EX instruction writes a register
EX_MemToReg  input  1  EX instruction is a load
EX_MduStart  input  1  EX instruction is mult/multu/div/divu
EX_Redirect  input  1  branch taken or jump resolved in EX
PC_Write  output  1  PC update enable
IFID_Write  output  1  IF/ID register enable
IFID_Flush  output  1  clear IF/ID to a NOP
IDEX_Flush  output  1  insert a bubble into ID/EX
MduBusy  output  1  MDU busy state (visible)
StallCnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst_n=0): state=RUN, busy counter=0, StallCnt=0, MduBusy=0. Outputs while in reset: PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Flush=0.
- load_use (combinational) = EX_RegWrite & EX_MemToReg & (EX_rt!=0) & ((ID_UseRs & ID_rs==EX_rt) | (ID_UseRt & ID_rt==EX_rt & ~ID_MemWrite)).
- A store whose only match is on rt does not stall; WB-stage store-data forwarding covers that case.
- mdu_stall = (state==MDU_BUSY) & ID_MduUse.
- stall = (load_use | mdu_stall) & ~EX_Redirect.
- FSM states: RUN and MDU_BUSY.
  - RUN→MDU_BUSY when EX_MduStart=1; busy counter loads MDU_LAT.
  - In MDU_BUSY the counter decrements by 1 every cycle. At counter==1 the next state is RUN and the counter becomes 0.
  - EX_MduStart while already in MDU_BUSY reloads the counter to MDU_LAT. The stall rule normally prevents this; the reload is defensive.
- MduBusy = (state==MDU_BUSY), registered.
- Outputs are combinational from the current state and inputs, with zero-cycle latency:
  - EX_Redirect=1: IFID_Flush=1, IDEX_Flush=1, PC_Write=1, IFID_Write=1. Redirect has priority over every stall.
  - else stall=1: PC_Write=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0.
  - else: PC_Write=1, IFID_Write=1, both flushes 0.
- A load-use stall lasts exactly one cycle, because the bubble moves the load out of EX.
- An MDU stall lasts until the counter expires. ID_MduUse in the cycle the state returns to RUN does not stall.
- A redirect during MDU_BUSY flushes but does not touch the MDU counter.
- StallCnt increments by 1 on every clock edge where stall=1 and saturates at all-ones with no wrap.
- Reset mid-stall returns to RUN immediately, and outputs revert to the reset values asynchronously.

Test Plan:
- Load-use on rs: EX lw with rt=5, ID add with rs=5 → exactly one cycle of PC_Write=0, IFID_Write=0, IDEX_Flush=1; next cycle free-running; StallCnt=1.
- Load→store rt: EX lw rt=7, ID sw with rt=7, UseRs=1, rs=3 → no stall. Same case with ID rs=7 → 1-cycle stall.
- $zero and non-load: EX lw with rt=0 matching ID rs=0 → no stall. EX add with RegWrite=1, MemToReg=0, matching → no stall.
- MDU: EX_MduStart pulse with MDU_LAT=8, then ID mflo held → MduBusy high for 8 cycles; stall for each of the busy cycles while mflo sits in ID; release in the cycle MduBusy falls; StallCnt increases by the stalled cycles. A non-MDU ID instruction during busy → no stall.
- Priority: load_use=1 and EX_Redirect=1 together → IFID_Flush=1, IDEX_Flush=1, PC_Write=1; StallCnt unchanged.
- Reset and saturation: assert rst_n=0 mid-MDU_BUSY → MduBusy=0 and outputs at reset values without waiting for a clock edge. With CNT_W=4, 20 stall cycles → StallCnt holds 15.
